ddr_arbiter: RTL



---
 rtl/ddr_arb_pkg.sv | 25 ++
 rtl/ddr_refresh_timer.sv | 62 ++++++
 rtl/ddr_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared encodings and default timing constants for the DDR arbiter.
// Included by ddr_refresh_timer and ddr_arbiter.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_REFRESH = 2'b11
    } ddr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int DATA_W               = 32;
    localparam int DEF_ADDR_W           = 24;
    localparam int DEF_REFRESH_INTERVAL = 1040;  // 7.8 us at 133 MHz
    localparam int DEF_MAX_PENDING      = 8;
    localparam int DEF_URGENT_THRESH    = 6;
    localparam int DEF_STARVE_LIMIT     = 4;

endpackage

// File: rtl/ddr_refresh_timer.sv
// Auto-refresh interval timer with a saturating count of postponed refreshes
// and a sticky overflow flag. The timer only runs while init_done is high.
module ddr_refresh_timer
    import ddr_arb_pkg::*;
#(
    parameter int INTERVAL      = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING   = DEF_MAX_PENDING,
    parameter int URGENT_THRESH = DEF_URGENT_THRESH,
    localparam int CNT_W        = $clog2(INTERVAL),
    localparam int PEND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk133_p,
    input  logic              rst,
    input  logic              init_done,
    input  logic              refresh_accepted,
    output logic [PEND_W-1:0] pending,
    output logic              urgent,
    output logic              overflow
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              tick;

    always_comb begin
        tick       = init_done && (cnt_q == CNT_W'(INTERVAL - 1));
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (init_done) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        // A tick and an accepted refresh in the same cycle cancel out.
        if (tick && !refresh_accepted) begin
            if (pending_q == PEND_W'(MAX_PENDING)) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (refresh_accepted && !tick && pending_q != '0) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign urgent   = (pending_q >= PEND_W'(URGENT_THRESH));
    assign overflow = overflow_q;

endmodule

// File: rtl/ddr_arbiter.sv
// Arbitrates display reads, draw writes and auto-refresh onto one DDR command
// engine, one transaction at a time. Define DDR_ARB_STATS_EN for stat_* counters.
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEF_MAX_PENDING,
    parameter int URGENT_THRESH    = DEF_URGENT_THRESH,
    parameter int STARVE_LIMIT     = DEF_STARVE_LIMIT
) (
    input  logic              clk133_p,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              ctl_cmd_valid,
    input  logic              ctl_cmd_ready,
    output logic [1:0]        ctl_op,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_rdata,
`ifdef DDR_ARB_STATS_EN
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_refreshes,
    output logic [15:0]       stat_max_wait,
`endif
    output logic              refresh_overflow
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q;
    ddr_op_e           ctl_op_q;
    ddr_op_e           pick_op;
    logic              ctl_cmd_valid_q;
    logic [ADDR_W-1:0] ctl_addr_q;
    logic [DATA_W-1:0] ctl_wdata_q;
    logic              rd_gnt_q, wr_gnt_q, rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [STV_W-1:0]  starve_q;
    logic [PEND_W-1:0] pending;
    logic              urgent;
    logic              overflow;
    logic              refresh_accepted;

    assign refresh_accepted = (state_q == ST_ISSUE) && ctl_cmd_valid_q &&
                              ctl_cmd_ready && (ctl_op_q == OP_REFRESH);

    ddr_refresh_timer #(
        .INTERVAL      (REFRESH_INTERVAL),
        .MAX_PENDING   (MAX_PENDING),
        .URGENT_THRESH (URGENT_THRESH)
    ) u_timer (
        .clk133_p         (clk133_p),
        .rst              (rst),
        .init_done        (init_done),
        .refresh_accepted (refresh_accepted),
        .pending          (pending),
        .urgent           (urgent),
        .overflow         (overflow)
    );

    // Fixed priority: urgent refresh, starved write, read, write, lazy refresh.
    always_comb begin
        pick_op = OP_NONE;
        if (state_q == ST_IDLE && init_done) begin
            if (urgent)                                              pick_op = OP_REFRESH;
            else if (starve_q == STV_W'(STARVE_LIMIT) && wr_req)     pick_op = OP_WRITE;
            else if (rd_req)                                         pick_op = OP_READ;
            else if (wr_req)                                         pick_op = OP_WRITE;
            else if (pending != '0)                                  pick_op = OP_REFRESH;
        end
    end

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ctl_op_q        <= OP_NONE;
            ctl_cmd_valid_q <= 1'b0;
            ctl_addr_q      <= '0;
            ctl_wdata_q     <= '0;
            rd_gnt_q        <= 1'b0;
            wr_gnt_q        <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            starve_q        <= '0;
        end else begin
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_op != OP_NONE) begin
                        state_q         <= ST_ISSUE;
                        ctl_cmd_valid_q <= 1'b1;
                        ctl_op_q        <= pick_op;
                        ctl_addr_q      <= (pick_op == OP_READ)  ? rd_addr :
                                           (pick_op == OP_WRITE) ? wr_addr : '0;
                        ctl_wdata_q     <= (pick_op == OP_WRITE) ? wr_data : '0;
                        // Grant lands on the first ISSUE cycle.
                        rd_gnt_q        <= (pick_op == OP_READ);
                        wr_gnt_q        <= (pick_op == OP_WRITE);
                        if (pick_op == OP_READ) begin
                            if (!wr_req)
                                starve_q <= '0;
                            else if (starve_q != STV_W'(STARVE_LIMIT))
                                starve_q <= starve_q + 1'b1;
                        end else if (pick_op == OP_WRITE) begin
                            starve_q <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ctl_cmd_ready) begin
                        ctl_cmd_valid_q <= 1'b0;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ctl_done) begin
                        state_q <= ST_IDLE;
                        if (ctl_op_q == OP_READ) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= ctl_rdata;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_gnt           = rd_gnt_q;
    assign wr_gnt           = wr_gnt_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign ctl_cmd_valid    = ctl_cmd_valid_q;
    assign ctl_op           = ctl_op_q;
    assign ctl_addr         = ctl_addr_q;
    assign ctl_wdata        = ctl_wdata_q;
    assign refresh_overflow = overflow;

`ifdef DDR_ARB_STATS_EN
    logic [31:0] stat_reads_q, stat_writes_q, stat_refreshes_q;
    logic [15:0] wait_cnt_q, stat_max_wait_q;
    logic        cmd_accepted;

    assign cmd_accepted = (state_q == ST_ISSUE) && ctl_cmd_ready;

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            stat_reads_q     <= '0;
            stat_writes_q    <= '0;
            stat_refreshes_q <= '0;
            wait_cnt_q       <= '0;
            stat_max_wait_q  <= '0;
        end else begin
            if (cmd_accepted && ctl_op_q == OP_READ && stat_reads_q != '1)
                stat_reads_q <= stat_reads_q + 1'b1;
            if (cmd_accepted && ctl_op_q == OP_WRITE && stat_writes_q != '1)
                stat_writes_q <= stat_writes_q + 1'b1;
            if (cmd_accepted && ctl_op_q == OP_REFRESH && stat_refreshes_q != '1)
                stat_refreshes_q <= stat_refreshes_q + 1'b1;
            // wait_cnt_q holds the cycles rd_req was high before this grant.
            if (rd_gnt_q) begin
                wait_cnt_q <= '0;
                if (wait_cnt_q > stat_max_wait_q)
                    stat_max_wait_q <= wait_cnt_q;
            end else if (rd_req && wait_cnt_q != '1) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign stat_reads     = stat_reads_q;
    assign stat_writes    = stat_writes_q;
    assign stat_refreshes = stat_refreshes_q;
    assign stat_max_wait  = stat_max_wait_q;
`endif

endmodule
